// File: rtl/param_risc_pkg.sv
// Shared opcodes, FSM encoding and instruction-field offsets for param_risc_core.
package param_risc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_LI   = 4'h7;
  localparam logic [3:0] OP_BRZ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int unsigned RS1_LO = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  function automatic int unsigned rs2_lo(input int unsigned reg_aw);
    return 32'd4 + reg_aw;
  endfunction

  function automatic int unsigned rd_lo(input int unsigned reg_aw);
    return 32'd4 + 32'd2 * reg_aw;
  endfunction

endpackage

// File: rtl/param_risc_alu.sv
// Combinational ALU for opcodes 0-7; c is carry, borrow or shifted-out bit.
module param_risc_alu
  import param_risc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] y,
  output logic              c,
  output logic              z
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  // Result and carry selection; logic ops and LI leave carry cleared.
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b};
    diff_s = {1'b0, a} - {1'b0, b};
    y      = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: {c, y} = sum_s;
      OP_SUB: {c, y} = diff_s;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SHL: begin
        y = {a[DATA_W-2:0], 1'b0};
        c = a[DATA_W-1];
      end
      OP_SHR: begin
        y = {1'b0, a[DATA_W-1:1]};
        c = a[0];
      end
      OP_LI:  y = b;
      default: y = '0;
    endcase
    z = (y == '0);
  end

endmodule

// File: rtl/param_risc_core.sv
// Multi-cycle FETCH/EXEC core with external instruction fetch handshake.
module param_risc_core
  import param_risc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int PC_W   = 4,
  localparam int INSTR_W = 4 + 3 * REG_AW
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [DATA_W-1:0]  result,
  output logic               result_valid,
  output logic               flag_z,
  output logic               flag_c,
  output logic               halted
);

  localparam int NREG   = 1 << REG_AW;
  localparam int RS2_LO = int'(rs2_lo(REG_AW));
  localparam int RD_LO  = int'(rd_lo(REG_AW));

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                flag_z_q, flag_z_d;
  logic                flag_c_q, flag_c_d;
  logic                wr_en_s;

  logic [3:0]          op_s;
  logic [REG_AW-1:0]   rs1_s, rs2_s, rd_s;
  logic [2*REG_AW-1:0] imm_s;
  logic [DATA_W-1:0]   a_s, b_s, alu_y_s;
  logic                alu_c_s, alu_z_s;

  // Field decode and operand read straight from IR.
  always_comb begin
    op_s  = ir_q[3:0];
    rs1_s = ir_q[RS1_LO +: REG_AW];
    rs2_s = ir_q[RS2_LO +: REG_AW];
    rd_s  = ir_q[RD_LO +: REG_AW];
    imm_s = {rs2_s, rs1_s};
    a_s   = regs_q[rs1_s];
    if (op_s == OP_LI) begin
      b_s = DATA_W'(imm_s);
    end else begin
      b_s = regs_q[rs2_s];
    end
  end

  param_risc_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (a_s),
    .b  (b_s),
    .op (op_s),
    .y  (alu_y_s),
    .c  (alu_c_s),
    .z  (alu_z_s)
  );

  // Next-state, pc, writeback and flag logic.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    ir_d           = ir_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    flag_z_d       = flag_z_q;
    flag_c_d       = flag_c_q;
    wr_en_s        = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = EXEC;
        end else begin
          state_d = FETCH;
        end
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_q + PC_W'(1);
        case (op_s)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_LI: begin
            wr_en_s        = 1'b1;
            result_d       = alu_y_s;
            result_valid_d = 1'b1;
            flag_z_d       = alu_z_s;
            flag_c_d       = alu_c_s;
          end
          OP_BRZ: begin
            if (regs_q[rd_s] == '0) begin
              pc_d = imm_s[PC_W-1:0];
            end else begin
              pc_d = pc_q + PC_W'(1);
            end
          end
          OP_JMP:  pc_d = imm_s[PC_W-1:0];
          OP_HALT: begin
            state_d = HALT;
            pc_d    = pc_q;
          end
          default: pc_d = pc_q + PC_W'(1);
        endcase
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= FETCH;
      pc_q           <= '0;
      ir_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      flag_z_q       <= 1'b0;
      flag_c_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      flag_z_q       <= flag_z_d;
      flag_c_q       <= flag_c_d;
    end
  end

  // Register file; source operands are read before this edge, so rd==rs uses the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_s) begin
      regs_q[rd_s] <= alu_y_s;
    end
  end

  assign imem_req     = (state_q == FETCH);
  assign imem_addr    = pc_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign flag_z       = flag_z_q;
  assign flag_c       = flag_c_q;
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_param_risc_core.sv
// Directed, table-driven bench for param_risc_core at default parameters.
module tb_param_risc_core;
  import param_risc_pkg::*;

  localparam int DATA_W  = 8;
  localparam int REG_AW  = 2;
  localparam int PC_W    = 4;
  localparam int INSTR_W = 10;
  localparam int NVEC    = 24;

  logic               clk = 1'b0;
  logic               reset;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [DATA_W-1:0]  result;
  logic               result_valid;
  logic               flag_z;
  logic               flag_c;
  logic               halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic               valid;
    logic [DATA_W-1:0]  res;
    logic               z;
    logic               c;
    logic [PC_W-1:0]    npc;
  } vec_t;

  vec_t vecs [NVEC];

  param_risc_core #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .result       (result),
    .result_valid (result_valid),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                             input logic [1:0] rs1, input logic [1:0] rs2);
    return {rd, rs2, rs1, op};
  endfunction

  function automatic logic [INSTR_W-1:0] imm_op(input logic [3:0] op, input logic [1:0] rd,
                                                input logic [3:0] imm);
    return {rd, imm, op};
  endfunction

  // Present an instruction in FETCH, ack it, and run through EXEC; ends #1 after the EXEC exit edge.
  task automatic step(input logic [INSTR_W-1:0] instr, input string name);
    imem_rdata = instr;
    imem_ack   = 1'b1;
    @(posedge clk); #1;
    chk({name, " req low in exec"}, 32'(imem_req), 32'd0);
    imem_rdata = {INSTR_W{1'b1}};
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{imm_op(OP_LI, 2'd1, 4'h5),       1'b1, 8'h05, 1'b0, 1'b0, 4'h1};
    vecs[1]  = '{imm_op(OP_LI, 2'd2, 4'h3),       1'b1, 8'h03, 1'b0, 1'b0, 4'h2};
    vecs[2]  = '{enc(OP_ADD, 2'd3, 2'd1, 2'd2),   1'b1, 8'h08, 1'b0, 1'b0, 4'h3};
    vecs[3]  = '{imm_op(OP_LI, 2'd1, 4'hF),       1'b1, 8'h0F, 1'b0, 1'b0, 4'h4};
    vecs[4]  = '{enc(OP_SHL, 2'd1, 2'd1, 2'd0),   1'b1, 8'h1E, 1'b0, 1'b0, 4'h5};
    vecs[5]  = '{enc(OP_SHL, 2'd1, 2'd1, 2'd0),   1'b1, 8'h3C, 1'b0, 1'b0, 4'h6};
    vecs[6]  = '{enc(OP_SHL, 2'd1, 2'd1, 2'd0),   1'b1, 8'h78, 1'b0, 1'b0, 4'h7};
    vecs[7]  = '{enc(OP_SHL, 2'd1, 2'd1, 2'd0),   1'b1, 8'hF0, 1'b0, 1'b0, 4'h8};
    vecs[8]  = '{enc(OP_ADD, 2'd1, 2'd1, 2'd1),   1'b1, 8'hE0, 1'b0, 1'b1, 4'h9};
    vecs[9]  = '{enc(OP_SUB, 2'd2, 2'd0, 2'd1),   1'b1, 8'h20, 1'b0, 1'b1, 4'hA};
    vecs[10] = '{enc(OP_XOR, 2'd3, 2'd3, 2'd3),   1'b1, 8'h00, 1'b1, 1'b0, 4'hB};
    vecs[11] = '{enc(OP_OR,  2'd3, 2'd1, 2'd2),   1'b1, 8'hE0, 1'b0, 1'b0, 4'hC};
    vecs[12] = '{enc(OP_AND, 2'd3, 2'd2, 2'd1),   1'b1, 8'h20, 1'b0, 1'b0, 4'hD};
    vecs[13] = '{imm_op(OP_LI, 2'd3, 4'h9),       1'b1, 8'h09, 1'b0, 1'b0, 4'hE};
    vecs[14] = '{enc(OP_SHR, 2'd3, 2'd3, 2'd0),   1'b1, 8'h04, 1'b0, 1'b1, 4'hF};
    vecs[15] = '{enc(OP_SHL, 2'd1, 2'd1, 2'd0),   1'b1, 8'hC0, 1'b0, 1'b1, 4'h0};
    vecs[16] = '{enc(4'hA, 2'd1, 2'd1, 2'd1),     1'b0, 8'hC0, 1'b0, 1'b1, 4'h1};
    vecs[17] = '{imm_op(OP_JMP, 2'd0, 4'hF),      1'b0, 8'hC0, 1'b0, 1'b1, 4'hF};
    vecs[18] = '{enc(4'hE, 2'd0, 2'd0, 2'd0),     1'b0, 8'hC0, 1'b0, 1'b1, 4'h0};
    vecs[19] = '{imm_op(OP_JMP, 2'd0, 4'h2),      1'b0, 8'hC0, 1'b0, 1'b1, 4'h2};
    vecs[20] = '{imm_op(OP_BRZ, 2'd0, 4'h7),      1'b0, 8'hC0, 1'b0, 1'b1, 4'h7};
    vecs[21] = '{imm_op(OP_JMP, 2'd0, 4'h2),      1'b0, 8'hC0, 1'b0, 1'b1, 4'h2};
    vecs[22] = '{imm_op(OP_BRZ, 2'd1, 4'h7),      1'b0, 8'hC0, 1'b0, 1'b1, 4'h3};
    vecs[23] = '{imm_op(OP_JMP, 2'd0, 4'h4),      1'b0, 8'hC0, 1'b0, 1'b1, 4'h4};

    reset      = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst result", 32'(result), 32'd0);
    chk("rst valid", 32'(result_valid), 32'd0);
    chk("rst flag_z", 32'(flag_z), 32'd0);
    chk("rst flag_c", 32'(flag_c), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    reset = 1'b0;
    chk("rst req", 32'(imem_req), 32'd1);
    chk("rst addr", 32'(imem_addr), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].instr, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d valid", i), 32'(result_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d result", i), 32'(result), 32'(vecs[i].res));
      chk($sformatf("vec%0d flag_z", i), 32'(flag_z), 32'(vecs[i].z));
      chk($sformatf("vec%0d flag_c", i), 32'(flag_c), 32'(vecs[i].c));
      chk($sformatf("vec%0d next addr", i), 32'(imem_addr), 32'(vecs[i].npc));
      chk($sformatf("vec%0d req", i), 32'(imem_req), 32'd1);
    end

    // Fetch stall: request held with a stable address and no pulse.
    imem_ack   = 1'b0;
    imem_rdata = imm_op(OP_LI, 2'd2, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d req", i), 32'(imem_req), 32'd1);
      chk($sformatf("stall%0d addr", i), 32'(imem_addr), 32'd4);
      chk($sformatf("stall%0d valid", i), 32'(result_valid), 32'd0);
    end
    step(imm_op(OP_LI, 2'd2, 4'h0), "stall li");
    chk("stall li valid", 32'(result_valid), 32'd1);
    chk("stall li result", 32'(result), 32'd0);
    chk("stall li flag_z", 32'(flag_z), 32'd1);
    chk("stall li addr", 32'(imem_addr), 32'd5);
    step(imm_op(OP_JMP, 2'd0, 4'h4), "jmp4");
    chk("jmp4 addr", 32'(imem_addr), 32'd4);

    // HALT at pc 4, then hold with ack toggling.
    step(enc(OP_HALT, 2'd0, 2'd0, 2'd0), "halt");
    chk("halt halted", 32'(halted), 32'd1);
    chk("halt req", 32'(imem_req), 32'd0);
    chk("halt valid", 32'(result_valid), 32'd0);
    for (int i = 0; i < 20; i++) begin
      imem_ack   = i[0];
      imem_rdata = imm_op(OP_LI, 2'd1, 4'h7);
      @(posedge clk); #1;
      chk($sformatf("hold%0d addr", i), 32'(imem_addr), 32'd4);
      chk($sformatf("hold%0d halted", i), 32'(halted), 32'd1);
      chk($sformatf("hold%0d req", i), 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;
    reset    = 1'b1;
    #2;
    chk("halt rst addr", 32'(imem_addr), 32'd0);
    chk("halt rst halted", 32'(halted), 32'd0);
    chk("halt rst req", 32'(imem_req), 32'd1);
    chk("halt rst flag_c", 32'(flag_c), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset during EXEC of ADD r3 aborts the write and the pulse.
    step(imm_op(OP_LI, 2'd1, 4'h5), "ab li1");
    chk("ab li1 result", 32'(result), 32'd5);
    step(imm_op(OP_LI, 2'd2, 4'h3), "ab li2");
    chk("ab li2 result", 32'(result), 32'd3);
    imem_rdata = enc(OP_ADD, 2'd3, 2'd1, 2'd2);
    imem_ack   = 1'b1;
    @(posedge clk); #1;
    chk("ab in exec", 32'(imem_req), 32'd0);
    imem_ack = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("ab valid", 32'(result_valid), 32'd0);
    chk("ab result", 32'(result), 32'd0);
    chk("ab addr", 32'(imem_addr), 32'd0);
    chk("ab req", 32'(imem_req), 32'd1);
    @(posedge clk); #1;
    chk("ab no late pulse", 32'(result_valid), 32'd0);
    step(enc(OP_OR, 2'd1, 2'd3, 2'd3), "ab read r3");
    chk("ab r3 valid", 32'(result_valid), 32'd1);
    chk("ab r3 value", 32'(result), 32'd0);
    chk("ab r3 flag_z", 32'(flag_z), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
